// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 front end.
package sha256_pkg;

    localparam int         BLOCK_SIZE    = 256;
    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam int         LEN_FIELD_W   = 64;
    localparam int         BYTES_PER_BLK = 64;

    typedef enum logic [2:0] {
        ABSORB,
        OUT_MID,
        OUT_LAST,
        PAD1,
        PAD2
    } pad_state_e;

endpackage

// File: rtl/sha256_padder.sv
// Purpose: packs a byte stream into padded 512-bit SHA-256 blocks (0x80, zero fill, 64-bit length); optional SHA256_PADDER_OVF_EN adds ovf_o.
// Latency: blk_valid_o rises the cycle after the accepting edge; an extra padding-only block costs one more cycle.
// Backpressure: single block buffer; ready_o is low from block completion until the consumer takes it.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    valid_i,
    input  logic                    keep_i,
    input  logic [7:0]              data_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [2*BLOCK_SIZE-1:0] blk_o,
    output logic                    blk_valid_o,
    input  logic                    blk_ready_i,
    output logic                    blk_first_o,
    output logic                    blk_last_o
`ifdef SHA256_PADDER_OVF_EN
    ,
    output logic                    ovf_o
`endif
);

    pad_state_e              state_q, state_d;
    pad_state_e              pend_q, pend_d;
    logic [6:0]              n_q, n_d, n_after;
    logic [LEN_W-1:0]        bitcnt_q, bitcnt_d;
    logic                    first_q, first_d;
    logic [2*BLOCK_SIZE-1:0] blk_q, blk_d;
    logic [LEN_FIELD_W-1:0]  len_field;
`ifdef SHA256_PADDER_OVF_EN
    logic                    ovf_q, ovf_d;
    logic [LEN_W:0]          cnt_sum;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ABSORB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        n_d         = n_q;
        bitcnt_d    = bitcnt_q;
        first_d     = first_q;
        blk_d       = blk_q;
        n_after     = n_q + 7'(keep_i);
        ready_o     = (state_q == ABSORB);
        blk_valid_o = (state_q == OUT_MID) || (state_q == OUT_LAST);
`ifdef SHA256_PADDER_OVF_EN
        ovf_d       = ovf_q;
        cnt_sum     = {1'b0, bitcnt_q} + (LEN_W+1)'(8);
`endif

        if (ready_o && valid_i && keep_i) begin
            n_d = n_after;
`ifdef SHA256_PADDER_OVF_EN
            bitcnt_d = cnt_sum[LEN_W-1:0];
            ovf_d    = ovf_q | cnt_sum[LEN_W];
`else
            bitcnt_d = bitcnt_q + LEN_W'(8);
`endif
        end

        // Length is taken after this cycle's byte so the final byte is counted.
`ifdef SHA256_PADDER_OVF_EN
        len_field = ovf_d ? LEN_FIELD_W'({LEN_W{1'b1}}) : LEN_FIELD_W'(bitcnt_d);
`else
        len_field = LEN_FIELD_W'(bitcnt_d);
`endif

        case (state_q)
            ABSORB: begin
                if (valid_i) begin
                    for (int i = 0; i < BYTES_PER_BLK; i++) begin
                        if (keep_i && i == int'(n_q))
                            blk_d[511-8*i -: 8] = data_i;
                        if (last_i && i == int'(n_after))
                            blk_d[511-8*i -: 8] = PAD_BYTE;
                        if (last_i && i > int'(n_after))
                            blk_d[511-8*i -: 8] = 8'h00;
                    end
                    if (last_i) begin
                        if (n_after <= 7'd55) begin
                            blk_d[LEN_FIELD_W-1:0] = len_field;
                            state_d = OUT_LAST;
                        end else begin
                            state_d = OUT_MID;
                            pend_d  = (n_after == 7'd64) ? PAD1 : PAD2;
                        end
                    end else if (n_after == 7'd64) begin
                        state_d = OUT_MID;
                        pend_d  = ABSORB;
                    end
                end
            end
            OUT_MID: begin
                if (blk_ready_i) begin
                    state_d = pend_q;
                    pend_d  = ABSORB;
                    n_d     = '0;
                    first_d = 1'b0;
                end
            end
            OUT_LAST: begin
                if (blk_ready_i) begin
                    state_d  = ABSORB;
                    n_d      = '0;
                    bitcnt_d = '0;
                    first_d  = 1'b1;
`ifdef SHA256_PADDER_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            PAD1: begin
                blk_d   = {PAD_BYTE, 440'd0, len_field};
                state_d = OUT_LAST;
            end
            PAD2: begin
                blk_d   = {448'd0, len_field};
                state_d = OUT_LAST;
            end
            default: state_d = ABSORB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q   <= ABSORB;
            n_q      <= '0;
            bitcnt_q <= '0;
            first_q  <= 1'b1;
            blk_q    <= '0;
`ifdef SHA256_PADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            pend_q   <= pend_d;
            n_q      <= n_d;
            bitcnt_q <= bitcnt_d;
            first_q  <= first_d;
            blk_q    <= blk_d;
`ifdef SHA256_PADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign blk_o       = blk_q;
    assign blk_first_o = blk_valid_o & first_q;
    assign blk_last_o  = (state_q == OUT_LAST);
`ifdef SHA256_PADDER_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: expected blocks are queued as messages are driven and popped on each block handshake.
module tb_sha256_padder;

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rstn_i;
    logic         valid_i;
    logic         keep_i;
    logic [7:0]   data_i;
    logic         last_i;
    logic         ready_o;
    logic [511:0] blk_o;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic         blk_first_o;
    logic         blk_last_o;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'd0};

    sha256_padder #(.LEN_W(64)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .keep_i      (keep_i),
        .data_i      (data_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .blk_o       (blk_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_first_o (blk_first_o),
        .blk_last_o  (blk_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference padding: append 0x80, zero to 56 mod 64, then the 64-bit bit length.
    function automatic void push_msg(input logic [7:0] m[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        int           nblk;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*bi + j];
            exp_q.push_back('{blk: b, first: (bi == 0), last: (bi == nblk - 1)});
        end
    endfunction

    // Called and returns at posedge+1.
    task automatic xfer(input logic k, input logic [7:0] d, input logic l);
        int t;
        t       = 0;
        valid_i = 1'b1;
        keep_i  = k;
        data_i  = d;
        last_i  = l;
        @(negedge clk);
        while (!ready_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("xfer_ready", {511'd0, ready_o}, 512'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        keep_i  = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$]);
        if (m.size() == 0)
            xfer(1'b0, 8'h00, 1'b1);
        else
            for (int i = 0; i < m.size(); i++) xfer(1'b1, m[i], i == m.size() - 1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check(tag, 512'(exp_q.size()), 512'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (blk_valid_o && blk_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_blk", {511'd0, blk_valid_o}, 512'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("blk", blk_o, e.blk);
                check("blk_first", {511'd0, blk_first_o}, {511'd0, e.first});
                check("blk_last", {511'd0, blk_last_o}, {511'd0, e.last});
                check("ready_while_held", {511'd0, ready_o}, 512'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[$];
        int         lens[6];

        rstn_i      = 1'b0;
        valid_i     = 1'b0;
        keep_i      = 1'b0;
        data_i      = 8'h00;
        last_i      = 1'b0;
        blk_ready_i = 1'b1;
        #12;
        check("rst_ready", {511'd0, ready_o}, 512'd1);
        check("rst_valid", {511'd0, blk_valid_o}, 512'd0);
        check("rst_blk", blk_o, 512'd0);
        check("rst_first", {511'd0, blk_first_o}, 512'd0);
        check("rst_last", {511'd0, blk_last_o}, 512'd0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back('{blk: ABC_BLK, first: 1'b1, last: 1'b1});
        send_msg(msg);
        check("abc_latency", {511'd0, blk_valid_o}, 512'd1);
        wait_drain("drain_abc");

        // empty message
        msg = {};
        exp_q.push_back('{blk: EMPTY_BLK, first: 1'b1, last: 1'b1});
        send_msg(msg);
        wait_drain("drain_empty");

        // 56 x 0x41: marker fits, length spills to a second block
        msg = {};
        repeat (56) msg.push_back(8'h41);
        push_msg(msg);
        send_msg(msg);
        wait_drain("drain_56");

        // 64 bytes 0x00..0x3F: full data block then marker+length block
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'(i));
        push_msg(msg);
        send_msg(msg);
        wait_drain("drain_64");

        // keep_i=0 no-op transfers inside "abc"
        exp_q.push_back('{blk: ABC_BLK, first: 1'b1, last: 1'b1});
        xfer(1'b1, 8'h61, 1'b0);
        xfer(1'b0, 8'hFF, 1'b0);
        xfer(1'b1, 8'h62, 1'b0);
        xfer(1'b0, 8'hFF, 1'b0);
        xfer(1'b1, 8'h63, 1'b1);
        wait_drain("drain_noop");

        // backpressure: held block stable, extra input ignored
        blk_ready_i = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back('{blk: ABC_BLK, first: 1'b1, last: 1'b1});
        send_msg(msg);
        valid_i = 1'b1;
        keep_i  = 1'b1;
        data_i  = 8'hEE;
        last_i  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {511'd0, blk_valid_o}, 512'd1);
            check("bp_ready", {511'd0, ready_o}, 512'd0);
            check("bp_blk", blk_o, ABC_BLK);
            check("bp_last", {511'd0, blk_last_o}, 512'd1);
        end
        @(posedge clk);
        #1;
        valid_i     = 1'b0;
        keep_i      = 1'b0;
        blk_ready_i = 1'b1;
        wait_drain("drain_bp");
        exp_q.push_back('{blk: ABC_BLK, first: 1'b1, last: 1'b1});
        send_msg(msg);
        wait_drain("drain_after_bp");

        // boundary lengths with random data
        lens = '{1, 55, 57, 63, 119, 120};
        foreach (lens[li]) begin
            msg = {};
            for (int i = 0; i < lens[li]; i++) msg.push_back(8'($urandom_range(0, 255)));
            push_msg(msg);
            send_msg(msg);
            wait_drain("drain_len");
        end

        // reset after 10 bytes discards the partial message
        for (int i = 0; i < 10; i++) xfer(1'b1, 8'h30 + 8'(i), 1'b0);
        #2;
        rstn_i = 1'b0;
        #1;
        check("mid_rst_ready", {511'd0, ready_o}, 512'd1);
        check("mid_rst_valid", {511'd0, blk_valid_o}, 512'd0);
        check("mid_rst_blk", blk_o, 512'd0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;

        // reset while a full block is held drops the pending output
        blk_ready_i = 1'b0;
        for (int i = 0; i < 64; i++) xfer(1'b1, 8'hA5, 1'b0);
        check("held_valid", {511'd0, blk_valid_o}, 512'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("held_rst_valid", {511'd0, blk_valid_o}, 512'd0);
        check("held_rst_first", {511'd0, blk_first_o}, 512'd0);
        @(posedge clk);
        #1;
        rstn_i      = 1'b1;
        blk_ready_i = 1'b1;

        msg = '{8'h61, 8'h62, 8'h63};
        exp_q.push_back('{blk: ABC_BLK, first: 1'b1, last: 1'b1});
        send_msg(msg);
        wait_drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
